// File: rtl/spi_master_trx_word.sv
// rtl/spi_master_trx_word.sv - single-character SPI master transceiver, all CPOL/CPHA modes
// SCK edges are strobes generated from S_SYSCLK; config is latched per character on S_CHAR_GO.
module spi_master_trx_word #(
    parameter int CHAR_NBITS = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int NUM_CS     = 4,
    localparam int LEN_W = $clog2(CHAR_NBITS),
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_TX_ONLY,
    input  logic                  S_LOOP,
    input  logic                  S_REV,
    input  logic [LEN_W-1:0]      S_CHAR_LEN,
    input  logic [DIV_WIDTH-1:0]  S_NDIVIDER,
    input  logic [SEL_W-1:0]      S_CS_SEL,
    input  logic                  S_CS_HOLD,
    input  logic                  S_CHAR_GO,
    output logic                  S_CHAR_BUSY,
    output logic                  S_CHAR_DONE,
    input  logic [CHAR_NBITS-1:0] S_WCHAR,
    output logic [CHAR_NBITS-1:0] S_RCHAR,
    output logic                  S_SPI_SCK,
    input  logic                  S_SPI_MISO,
    output logic                  S_SPI_MOSI,
    output logic [NUM_CS-1:0]     S_SPI_CS_N
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_OFF,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t state_q, state_d;

    logic                  cpol_q, cpha_q, tx_only_q, loop_q, rev_q, hold_q;
    logic [LEN_W-1:0]      len_q;
    logic [DIV_WIDTH-1:0]  div_q, div_cnt_q;
    logic [SEL_W-1:0]      sel_q;
    logic [LEN_W:0]        half_cnt_q;
    logic [CHAR_NBITS-1:0] tx_sr_q, rx_sr_q, rchar_q;
    logic                  sck_q, mosi_q, done_q, cs_held_q;
    logic [NUM_CS-1:0]     cs_n_q;

    logic                  phase_end, last_half, leading, go_ok, same_cs;
    logic                  cur_bit, next_bit, rx_bit;
    logic [LEN_W:0]        pad_new, pad_q;
    logic [CHAR_NBITS-1:0] tx_load, tx_next, rx_next, rx_just;

    // MSB-first characters are left-aligned in the shift register so the
    // first bit always sits at the top, whatever the character length.
    assign pad_new  = (LEN_W+1)'(CHAR_NBITS-1) - {1'b0, S_CHAR_LEN};
    assign pad_q    = (LEN_W+1)'(CHAR_NBITS-1) - {1'b0, len_q};
    assign tx_load  = S_REV ? (S_WCHAR << pad_new) : S_WCHAR;

    assign cur_bit  = rev_q ? tx_sr_q[CHAR_NBITS-1] : tx_sr_q[0];
    assign tx_next  = rev_q ? (tx_sr_q << 1) : (tx_sr_q >> 1);
    assign next_bit = rev_q ? tx_next[CHAR_NBITS-1] : tx_next[0];

    assign rx_bit   = loop_q ? mosi_q : S_SPI_MISO;
    assign rx_next  = rev_q ? {rx_sr_q[CHAR_NBITS-2:0], rx_bit}
                            : {rx_bit, rx_sr_q[CHAR_NBITS-1:1]};
    assign rx_just  = rev_q ? rx_sr_q : (rx_sr_q >> pad_q);

    assign phase_end = (div_cnt_q == div_q);
    assign last_half = (half_cnt_q == {len_q, 1'b1});
    assign leading   = ~half_cnt_q[0];
    assign go_ok     = S_ENABLE && S_CHAR_GO && !done_q;
    assign same_cs   = cs_held_q && (S_CS_SEL == sel_q);

    always_ff @(posedge S_SYSCLK) begin
        if (!S_RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (go_ok) begin
                    if (same_cs) begin
                        state_d = ST_SHIFT;
                    end else if (cs_held_q) begin
                        state_d = ST_CS_OFF;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_CS_OFF: state_d = ST_SETUP;
            ST_SETUP: begin
                if (phase_end) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (phase_end && last_half) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!S_ENABLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge S_SYSCLK) begin
        if (!S_RESETN) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_only_q  <= 1'b0;
            loop_q     <= 1'b0;
            rev_q      <= 1'b0;
            hold_q     <= 1'b0;
            len_q      <= '0;
            div_q      <= '0;
            sel_q      <= '0;
            div_cnt_q  <= '0;
            half_cnt_q <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rchar_q    <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            done_q     <= 1'b0;
            cs_held_q  <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            done_q <= 1'b0;
            if (!S_ENABLE) begin
                cs_n_q    <= '1;
                cs_held_q <= 1'b0;
                mosi_q    <= 1'b1;
                sck_q     <= S_CPOL;
                div_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (go_ok) begin
                            cpol_q     <= S_CPOL;
                            cpha_q     <= S_CPHA;
                            tx_only_q  <= S_TX_ONLY;
                            loop_q     <= S_LOOP;
                            rev_q      <= S_REV;
                            hold_q     <= S_CS_HOLD;
                            len_q      <= S_CHAR_LEN;
                            div_q      <= S_NDIVIDER;
                            sel_q      <= S_CS_SEL;
                            tx_sr_q    <= tx_load;
                            rx_sr_q    <= '0;
                            div_cnt_q  <= '0;
                            half_cnt_q <= '0;
                            sck_q      <= S_CPOL;
                            if (same_cs) begin
                                // SETUP is skipped, so the first bit must be on MOSI now
                                if (!S_CPHA) begin
                                    mosi_q <= S_REV ? tx_load[CHAR_NBITS-1] : tx_load[0];
                                end
                            end else if (cs_held_q) begin
                                cs_n_q    <= '1;
                                cs_held_q <= 1'b0;
                            end else begin
                                cs_n_q <= ~(NUM_CS'(1) << S_CS_SEL);
                            end
                        end else if (cs_held_q && !S_CS_HOLD) begin
                            cs_n_q    <= '1;
                            cs_held_q <= 1'b0;
                        end
                    end
                    ST_CS_OFF: begin
                        cs_n_q <= ~(NUM_CS'(1) << sel_q);
                    end
                    ST_SETUP: begin
                        if (phase_end) begin
                            div_cnt_q <= '0;
                            if (!cpha_q) begin
                                mosi_q <= cur_bit;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 1'b1;
                        end
                    end
                    ST_SHIFT: begin
                        if (phase_end) begin
                            div_cnt_q  <= '0;
                            sck_q      <= ~sck_q;
                            half_cnt_q <= half_cnt_q + 1'b1;
                            // sample edge is leading for CPHA=0, trailing for CPHA=1
                            if (leading != cpha_q) begin
                                rx_sr_q <= rx_next;
                            end else begin
                                tx_sr_q <= tx_next;
                                mosi_q  <= cpha_q ? cur_bit : next_bit;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (phase_end) begin
                            div_cnt_q <= '0;
                            done_q    <= 1'b1;
                            mosi_q    <= 1'b1;
                            cs_held_q <= hold_q;
                            if (!tx_only_q) begin
                                rchar_q <= rx_just;
                            end
                            if (!hold_q) begin
                                cs_n_q <= '1;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign S_CHAR_BUSY = (state_q != ST_IDLE);
    assign S_CHAR_DONE = done_q;
    assign S_RCHAR     = rchar_q;
    assign S_SPI_MOSI  = mosi_q;
    assign S_SPI_CS_N  = cs_n_q;
    assign S_SPI_SCK   = (state_q == ST_IDLE && !cs_held_q) ? S_CPOL : sck_q;

endmodule
